// File: rtl/accu_stack.sv
// Accumulator with carry, built-in add/sub/shift ALU and a LIFO save stack
// holding {carry, accumulator} pairs for context save.
module accu_stack #(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic [2:0]                   op,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         cy_i,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         cy_o,
    output logic                         zero_o,
    output logic                         sp_empty,
    output logic                         sp_full,
    output logic                         err_o
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_PUSH = 3'b110,
        OP_POP  = 3'b111
    } op_t;

    logic signed [DATA_WIDTH-1:0] r_acc;
    logic                         r_cy;
    logic [SP_W-1:0]              r_sp;
    logic                         r_err;
    logic [DATA_WIDTH:0]          r_mem [STACK_DEPTH];

    logic signed [DATA_WIDTH-1:0] w_acc_nxt;
    logic                         w_cy_nxt;
    logic [SP_W-1:0]              w_sp_nxt;
    logic                         w_err_nxt;
    logic                         w_push_we;
    logic [DATA_WIDTH:0]          w_sum;
    logic [DATA_WIDTH:0]          w_diff;
    logic [SP_W-1:0]              w_sp_dec;
    logic [DATA_WIDTH:0]          w_top;

    // Carry/borrow come out naturally as bit DATA_WIDTH of an unsigned (W+1)-bit result.
    assign w_sum    = {1'b0, r_acc} + {1'b0, data_in} + {{DATA_WIDTH{1'b0}}, cy_i};
    assign w_diff   = {1'b0, r_acc} - {1'b0, data_in} - {{DATA_WIDTH{1'b0}}, cy_i};
    assign w_sp_dec = r_sp - SP_W'(1);
    assign w_top    = r_mem[w_sp_dec[IDX_W-1:0]];

    always_comb begin
        w_acc_nxt = r_acc;
        w_cy_nxt  = r_cy;
        w_sp_nxt  = r_sp;
        w_err_nxt = r_err;
        w_push_we = 1'b0;
        if (ce) begin
            case (op_t'(op))
                OP_LOAD: begin
                    w_acc_nxt = data_in;
                    w_cy_nxt  = cy_i;
                end
                OP_ADD:  {w_cy_nxt, w_acc_nxt} = w_sum;
                OP_SUB:  {w_cy_nxt, w_acc_nxt} = w_diff;
                OP_SHL:  {w_cy_nxt, w_acc_nxt} = {r_acc, cy_i};
                OP_SHR:  {w_acc_nxt, w_cy_nxt} = {cy_i, r_acc};
                OP_PUSH: begin
                    if (r_sp < SP_MAX) begin
                        w_push_we = 1'b1;
                        w_sp_nxt  = r_sp + SP_W'(1);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                OP_POP: begin
                    if (r_sp != '0) begin
                        {w_cy_nxt, w_acc_nxt} = w_top;
                        w_sp_nxt              = w_sp_dec;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_cy  <= 1'b0;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_cy  <= w_cy_nxt;
            r_sp  <= w_sp_nxt;
            r_err <= w_err_nxt;
        end
    end

    // Stack storage is never reset; entries at or above sp are meaningless.
    always_ff @(posedge clk) begin
        if (w_push_we)
            r_mem[r_sp[IDX_W-1:0]] <= {r_cy, r_acc};
    end

    assign data_out = r_acc;
    assign cy_o     = r_cy;
    assign zero_o   = (r_acc == '0);
    assign sp_empty = (r_sp == '0);
    assign sp_full  = (r_sp == SP_MAX);
    assign err_o    = r_err;

endmodule
